// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider datapath.
package div_pkg;

   // Controller states; encodings are shared with neighbouring datapath blocks.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage : div_pkg

// File: rtl/borrow_subtractor.sv
// Combinational subtractor: diff = minuend - subtrahend, built as
// minuend + ~subtrahend + 1 on a full_adder ripple chain. A missing final
// carry means the subtraction borrowed (subtrahend > minuend).
module borrow_subtractor #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] minuend_i,
   input  logic [WIDTH-1:0] subtrahend_i,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o
);

   logic [WIDTH:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder u_fa (
         .a_i (minuend_i[i]),
         .b_i (~subtrahend_i[i]),
         .c_i (carry[i]),
         .s_o (diff_o[i]),
         .c_o (carry[i+1])
      );
   end

   assign borrow_o = ~carry[WIDTH];

endmodule : borrow_subtractor

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared with the ripple carry adder.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule : full_adder

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned radix-2 restoring divider with a Start/Done handshake.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for Start; results hold their last values
//   RUN   | one shift / trial subtraction per clock, WIDTH steps in total
//   DONE  | single-cycle Done pulse; Start here chains the next operation
//
// A zero divisor skips RUN and goes straight to DONE with an all-ones
// quotient, the dividend as remainder and DivByZero set.
module restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivByZero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] q_step;
   logic [WIDTH-1:0] r_step;
   logic             unused_diff_msb;

   // Partial remainder shifted left with the next dividend bit brought in.
   assign trial = {r_q, q_q[WIDTH-1]};

   borrow_subtractor #(
      .WIDTH (WIDTH + 1)
   ) u_sub (
      .minuend_i    (trial),
      .subtrahend_i ({1'b0, d_q}),
      .diff_o       (diff),
      .borrow_o     (borrow)
   );

   // On success the difference is below the divisor, so its top bit is
   // always zero and the remainder fits in WIDTH bits.
   assign unused_diff_msb = diff[WIDTH];

   assign q_step = {q_q[WIDTH-2:0], ~borrow};
   assign r_step = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];

   // State, datapath and result registers; reset clears everything.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         d_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state, datapath step and handshake outputs.
   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      Busy    = 1'b0;
      Done    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            Done = (state_q == DONE);
            if (Start) begin
               if (Divisor != '0) begin
                  d_d     = Divisor;
                  q_d     = Dividend;
                  r_d     = '0;
                  cnt_d   = CNT_INIT;
                  state_d = RUN;
               end else begin
                  quot_d  = '1;
                  rem_d   = Dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end
            end else begin
               state_d = IDLE;
            end
         end

         RUN: begin
            Busy  = 1'b1;
            q_d   = q_step;
            r_d   = r_step;
            cnt_d = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
               quot_d  = q_step;
               rem_d   = r_step;
               dbz_d   = 1'b0;
               state_d = DONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign Quotient  = quot_q;
   assign Remainder = rem_q;
   assign DivByZero = dbz_q;

endmodule : restoring_divider
